// File: rtl/ifu_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches from IM over req/ack and hands words to decode.
// Optional retire counter is enabled by defining IFU_RETIRE_CNT_EN.
module ifu_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_AW    = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      npc,
  input  logic             instr_ready,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [31:0]      pc_out,
  output logic             imem_req,
  output logic [IM_AW-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             fetch_err,
  output logic [31:0]      retire_cnt
);

  localparam logic [31:0] WIN_BYTES = 32'd4 << IM_AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t      stateR;
  logic [31:0] pcR;
  logic [31:0] instrR;
  logic        instrValidR;
  logic        imemReqR;
  logic        fetchErrR;

  // Offset is unsigned, so addresses below the base wrap high and fail the window test.
  function automatic logic npcIllegal(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - RESET_PC;
    return (addr[1:0] != 2'b00) || (off >= WIN_BYTES);
  endfunction

  // Fetch FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateR      <= IDLE;
      pcR         <= RESET_PC;
      instrR      <= 32'h0;
      instrValidR <= 1'b0;
      imemReqR    <= 1'b0;
      fetchErrR   <= 1'b0;
    end else begin
      case (stateR)
        IDLE: begin
          stateR   <= FETCH;
          imemReqR <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            instrR      <= imem_rdata;
            stateR      <= VALID;
            imemReqR    <= 1'b0;
            instrValidR <= 1'b1;
          end
        end
        VALID: begin
          if (instr_ready) begin
            pcR         <= npc;
            instrValidR <= 1'b0;
            if (npcIllegal(npc)) begin
              stateR    <= ERR;
              fetchErrR <= 1'b1;
            end else begin
              stateR   <= FETCH;
              imemReqR <= 1'b1;
            end
          end
        end
        ERR: begin
          instrValidR <= 1'b0;
          imemReqR    <= 1'b0;
          fetchErrR   <= 1'b1;
        end
        default: begin
          stateR      <= ERR;
          instrValidR <= 1'b0;
          imemReqR    <= 1'b0;
          fetchErrR   <= 1'b1;
        end
      endcase
    end
  end

  assign instr_valid = instrValidR;
  assign instr       = instrR;
  assign pc_out      = pcR;
  assign imem_req    = imemReqR;
  assign fetch_err   = fetchErrR;
  assign imem_addr   = IM_AW'((pcR - RESET_PC) >> 2);

`ifdef IFU_RETIRE_CNT_EN
  logic [31:0] retireCntR;

  // Counts every decode handshake, including the one that enters ERR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retireCntR <= 32'h0;
    end else if (stateR == VALID && instr_ready) begin
      retireCntR <= retireCntR + 32'd1;
    end else begin
      retireCntR <= retireCntR;
    end
  end

  assign retire_cnt = retireCntR;
`else
  assign retire_cnt = 32'h0;
`endif

endmodule
